// File: rtl/psum_accumulator.sv
// Accumulates groups of up to ACC_LEN sign-extended signed terms into a wide
// partial sum and presents each completed sum on a registered valid/ready output.
module psum_accumulator #(
  parameter int I_DATA_BW = 16,
  parameter int O_SUM_BW  = 21,
  parameter int ACC_LEN   = 9,
  parameter int CNT_BW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [I_DATA_BW-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [O_SUM_BW-1:0]  o_psum,
  output logic                 o_ovf
);

  localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(ACC_LEN - 1);

  logic [O_SUM_BW-1:0] acc_q, acc_d;
  logic [O_SUM_BW-1:0] psum_q, psum_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic                o_valid_q, o_valid_d;
  logic                o_ovf_q, o_ovf_d;
  logic [O_SUM_BW-1:0] ext_s, sum_s;
  logic                accept_s, close_s, add_ovf_s;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign i_ready = !(o_valid_q && !o_ready);
  assign o_valid = o_valid_q;
  assign o_psum  = psum_q;
  assign o_ovf   = o_ovf_q;

  // Next-state: accumulate, close a group, or drain the output register.
  always_comb begin
    ext_s     = O_SUM_BW'($signed(i_data));
    sum_s     = acc_q + ext_s;
    add_ovf_s = add_overflow(acc_q[O_SUM_BW-1], ext_s[O_SUM_BW-1], sum_s[O_SUM_BW-1]);
    accept_s  = i_valid && i_ready;
    close_s   = accept_s && (i_last || (cnt_q == LAST_CNT));

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    psum_d    = psum_q;
    o_ovf_d   = o_ovf_q;
    o_valid_d = o_valid_q && !o_ready;

    if (close_s) begin
      psum_d    = sum_s;
      o_ovf_d   = ovf_acc_q | add_ovf_s;
      o_valid_d = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (accept_s) begin
      acc_d     = sum_s;
      cnt_d     = cnt_q + CNT_BW'(1);
      ovf_acc_d = ovf_acc_q | add_ovf_s;
    end else begin
      acc_d     = acc_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      psum_q    <= '0;
      o_ovf_q   <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      psum_q    <= psum_d;
      o_ovf_q   <= o_ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench: default-parameter instance for directed groups, narrow
// (17-bit, ACC_LEN=4) instance for overflow and random traffic.
module tb_psum_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        v0, l0, r0, rdy0, ov0, of0;
  logic [15:0] d0;
  logic [20:0] ps0;
  logic        v1, l1, r1, rdy1, ov1, of1;
  logic [15:0] d1;
  logic [16:0] ps1;

  psum_accumulator #(.I_DATA_BW(16), .O_SUM_BW(21), .ACC_LEN(9), .CNT_BW(4)) dut (
    .clk(clk), .reset(reset), .i_valid(v0), .i_ready(rdy0), .i_data(d0), .i_last(l0),
    .o_valid(ov0), .o_ready(r0), .o_psum(ps0), .o_ovf(of0));

  psum_accumulator #(.I_DATA_BW(16), .O_SUM_BW(17), .ACC_LEN(4), .CNT_BW(3)) dut_r (
    .clk(clk), .reset(reset), .i_valid(v1), .i_ready(rdy1), .i_data(d1), .i_last(l1),
    .o_valid(ov1), .o_ready(r1), .o_psum(ps1), .o_ovf(of1));

  typedef struct { longint psum; bit ovf; } exp_t;
  exp_t   sbq[$];
  int     checks = 0;
  int     failures = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;

  function automatic longint wrap(input longint s, input int w);
    longint m;
    m = s & ((64'sd1 <<< w) - 64'sd1);
    if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
    return m;
  endfunction

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    sbq.delete();
  endtask

  // One clock cycle: drive, sample mid-cycle, update the reference model on accept.
  task automatic cycle(input int sel, input bit v, input logic [15:0] d, input bit l,
                       input bit r, output bit fire, output bit accd, output bit vv,
                       output bit rdy, output longint ps, output bit ov);
    int     w, len;
    longint s, lim;
    if (sel == 0) begin
      v0 = v; d0 = d; l0 = l; r0 = r; v1 = 1'b0; l1 = 1'b0; r1 = 1'b1;
    end else begin
      v1 = v; d1 = d; l1 = l; r1 = r; v0 = 1'b0; l0 = 1'b0; r0 = 1'b1;
    end
    @(negedge clk);
    if (sel == 0) begin
      rdy = rdy0; vv = ov0; ps = longint'($signed(ps0)); ov = of0; w = 21; len = 9;
    end else begin
      rdy = rdy1; vv = ov1; ps = longint'($signed(ps1)); ov = of1; w = 17; len = 4;
    end
    fire = vv && r;
    accd = v && rdy;
    if (accd) begin
      s   = m_acc + longint'($signed(d));
      lim = 64'sd1 <<< (w - 1);
      if (s >= lim || s < -lim) m_ovf = 1'b1;
      m_acc = wrap(s, w);
      if (l || m_cnt == len - 1) begin
        sbq.push_back('{psum: m_acc, ovf: m_ovf});
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v0 = 1'b0; d0 = 16'd0; l0 = 1'b0; r0 = 1'b1;
    v1 = 1'b0; d1 = 16'd0; l1 = 1'b0; r1 = 1'b1;
    #12;
    @(negedge clk);
    checks++;
    if ({ov0, of0, ps0, ov1, of1, ps1} !== 42'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b ovf=%b psum=%0d required zeros", ov0, of0, ps0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b%b required 11", rdy0, rdy1);
    end
    @(posedge clk); #1;
    model_clear();
  endtask

  // Terms 1..9 continuous: single output 45 exactly one cycle after the 9th accept.
  task automatic test_basic();
    bit fire, accd, vv, rdy, ov; longint ps; exp_t e;
    for (int k = 0; k < 12; k++) begin
      cycle(0, k < 9, 16'(k + 1), 1'b0, 1'b1, fire, accd, vv, rdy, ps, ov);
      checks++;
      if (fire !== (k == 9)) begin
        failures++;
        $display("FAIL basic_latency cycle %0d o_valid=%b required %b", k, fire, k == 9);
      end
      if (fire && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (ps !== 45 || ov !== 1'b0 || e.psum !== 45) begin
          failures++;
          $display("FAIL basic_sum got %0d ovf=%b required 45 ovf=0", ps, ov);
        end
      end
    end
  endtask

  // Extreme terms: nine of -32768 then nine of 32767.
  task automatic test_extremes();
    bit fire, accd, vv, rdy, ov; longint ps; int outs;
    longint want[2];
    want[0] = -294912; want[1] = 294903;
    outs = 0;
    for (int k = 0; k < 22; k++) begin
      cycle(0, k < 18, (k < 9) ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1, fire, accd, vv, rdy, ps, ov);
      if (fire) begin
        checks++;
        if (outs > 1 || ps !== want[outs] || ov !== 1'b0) begin
          failures++;
          $display("FAIL extremes_sum got %0d ovf=%b (output %0d)", ps, ov, outs);
        end
        if (sbq.size() > 0) void'(sbq.pop_front());
        outs++;
      end
    end
    checks++;
    if (outs !== 2) begin
      failures++;
      $display("FAIL extremes_count got %0d required 2", outs);
    end
    checks++;
    if (ps0 !== 21'h1B8000 - 21'h1B8000 + 21'(294903)) begin
      failures++;
      $display("FAIL extremes_hold got %0d required 294903", ps0);
    end
  endtask

  // Early close via i_last on the third term, then a full 9-term group.
  task automatic test_last();
    bit fire, accd, vv, rdy, ov; longint ps; exp_t e; int idx, outs;
    logic [15:0] t[12];
    t[0] = 16'd100; t[1] = -16'sd50; t[2] = 16'd7;
    for (int i = 3; i < 12; i++) t[i] = 16'(i * 311 - 1700);
    idx = 0; outs = 0;
    for (int k = 0; k < 30 && outs < 2; k++) begin
      cycle(0, idx < 12, (idx < 12) ? t[idx] : 16'd0, idx == 2, 1'b1, fire, accd, vv, rdy, ps, ov);
      if (accd) idx++;
      if (fire) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL last_unexpected got %0d", ps);
        end else begin
          e = sbq.pop_front();
          if (ps !== e.psum || ov !== e.ovf || (outs == 0 && ps !== 57)) begin
            failures++;
            $display("FAIL last_sum got %0d ovf=%b required %0d ovf=%b", ps, ov, e.psum, e.ovf);
          end
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 2 || sbq.size() != 0) begin
      failures++;
      $display("FAIL last_count got %0d outputs required 2", outs);
    end
  endtask

  // Output held off for 5 cycles while the next group streams.
  task automatic test_backpressure();
    bit fire, accd, vv, rdy, ov, rel, pend; longint ps, held; exp_t e; int idx, outs, stall;
    idx = 0; outs = 0; stall = 0; rel = 1'b0; pend = 1'b0; held = 0;
    for (int k = 0; k < 80 && outs < 2; k++) begin
      cycle(0, idx < 18, 16'(idx * 977 - 5000), 1'b0, rel, fire, accd, vv, rdy, ps, ov);
      if (accd) idx++;
      if (vv && !rel) begin
        checks++;
        if (rdy !== 1'b0 || (pend && ps !== held)) begin
          failures++;
          $display("FAIL bp_stall got ready=%b psum=%0d required ready=0 psum=%0d", rdy, ps, held);
        end
        held = ps; pend = 1'b1;
        stall++;
        if (stall == 5) rel = 1'b1;
      end
      if (fire) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL bp_unexpected got %0d", ps);
        end else begin
          e = sbq.pop_front();
          if (ps !== e.psum || ov !== e.ovf) begin
            failures++;
            $display("FAIL bp_sum got %0d required %0d", ps, e.psum);
          end
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 2 || idx !== 18 || stall !== 5) begin
      failures++;
      $display("FAIL bp_count got outs=%0d terms=%0d stall=%0d required 2 18 5", outs, idx, stall);
    end
  endtask

  // One-term groups every cycle sustain one output per cycle.
  task automatic test_back_to_back();
    bit fire, accd, vv, rdy, ov; longint ps; exp_t e;
    for (int k = 0; k < 11; k++) begin
      cycle(0, k < 10, 16'($urandom), 1'b1, 1'b1, fire, accd, vv, rdy, ps, ov);
      checks++;
      if (fire !== (k >= 1) || accd !== (k < 10)) begin
        failures++;
        $display("FAIL b2b_rate cycle %0d fire=%b accept=%b", k, fire, accd);
      end
      if (fire && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (ps !== e.psum) begin
          failures++;
          $display("FAIL b2b_sum got %0d required %0d", ps, e.psum);
        end
      end
    end
  endtask

  // Reset after 4 terms discards the partial sum; 9 terms of 2 then give 18.
  task automatic test_mid_reset();
    bit fire, accd, vv, rdy, ov; longint ps; int outs;
    for (int k = 0; k < 4; k++) cycle(0, 1'b1, 16'd1000, 1'b0, 1'b1, fire, accd, vv, rdy, ps, ov);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || ps0 !== 21'd0 || of0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got v=%b psum=%0d ovf=%b required 0", ov0, ps0, of0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    outs = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(0, k < 9, 16'd2, 1'b0, 1'b1, fire, accd, vv, rdy, ps, ov);
      if (fire) begin
        checks++;
        if (ps !== 18 || ov !== 1'b0) begin
          failures++;
          $display("FAIL midreset_sum got %0d required 18", ps);
        end
        outs++;
      end
    end
    checks++;
    if (outs !== 1) begin
      failures++;
      $display("FAIL midreset_count got %0d required 1", outs);
    end
    sbq.delete();
  endtask

  // Narrow instance: 4 x 32767 wraps to -4 with overflow, then random traffic.
  task automatic test_random();
    bit fire, accd, vv, rdy, ov, v, l, r; longint ps; exp_t e; logic [15:0] d; int pick;
    for (int k = 0; k < 7; k++) begin
      cycle(1, k < 4, 16'h7FFF, 1'b0, 1'b1, fire, accd, vv, rdy, ps, ov);
      if (fire) begin
        checks++;
        if (ps !== -4 || ov !== 1'b1) begin
          failures++;
          $display("FAIL ovf_forced got %0d ovf=%b required -4 ovf=1", ps, ov);
        end
        void'(sbq.pop_front());
      end
    end
    for (int k = 0; k < 10000 + 20; k++) begin
      v = (k < 10000) && ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) < 2);
      r = (k >= 10000) || ($urandom_range(0, 9) < 7);
      pick = $urandom_range(0, 9);
      d = (pick < 3) ? 16'h7FFF : (pick < 5) ? 16'h8000 : 16'($urandom);
      cycle(1, v, d, l, r, fire, accd, vv, rdy, ps, ov);
      checks++;
      if (rdy !== !(vv && !r)) begin
        failures++;
        $display("FAIL rand_ready cycle %0d got %b", k, rdy);
      end
      if (fire) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected cycle %0d got %0d", k, ps);
        end else begin
          e = sbq.pop_front();
          if (ps !== e.psum || ov !== e.ovf) begin
            failures++;
            $display("FAIL rand_sum cycle %0d got %0d ovf=%b required %0d ovf=%b",
                     k, ps, ov, e.psum, e.ovf);
          end
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL rand_drain got %0d pending required 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_last();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
